// File: rtl/sd_pkg.sv
// sd_pkg: shared types and constants for the SPI-mode SD command initiator.
//   sd_state_e   - command FSM states
//   FRAME_W      - command frame width (start bits + index + arg + crc + stop)
//   START_BITS   - leading '01' of every command frame
//   R1_IDLE      - value R1 holds when no response has been received
//   CMD0_*       - GO_IDLE_STATE index and its fixed CRC7
//   build_frame  - packs the command fields into a wire-order frame
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SEND,
    WAIT_R1,
    RECV,
    FINISH
  } sd_state_e;

  localparam int         FRAME_W    = 48;
  localparam logic [1:0] START_BITS = 2'b01;
  localparam logic [7:0] R1_IDLE    = 8'hFF;
  localparam logic [5:0] CMD0_INDEX = 6'd0;
  localparam logic [6:0] CMD0_CRC   = 7'h4A;

  function automatic logic [FRAME_W-1:0] build_frame(input logic [5:0]  index,
                                                     input logic [31:0] argument,
                                                     input logic [6:0]  crc7);
    return {START_BITS, index, argument, crc7, 1'b1};
  endfunction

endpackage

// File: rtl/sd_sck_gen.sv
// sd_sck_gen: SPI clock divider for the SD command link.
//   CLK100MHZ  - system clock
//   CPU_RESETN - asynchronous active-low reset
//   en         - count while high (link active)
//   clr        - synchronous clear of divider and SCK, wins over en
//   sck        - SPI clock, idle low, period 2*CLK_DIV system cycles
//   rise/fall  - one-cycle strobes in the cycle where sck is about to toggle
module sd_sck_gen #(
  parameter int CLK_DIV = 125
) (
  input  logic CLK100MHZ,
  input  logic CPU_RESETN,
  input  logic en,
  input  logic clr,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam logic [11:0] TERM = 12'(CLK_DIV - 1);

  logic [11:0] div_q;
  logic        term;

  // Strobes are combinational so the FSM acts on the same edge that moves SCK.
  assign term = en && (div_q == TERM);
  assign rise = term && !sck;
  assign fall = term && sck;

  // NOTE: sequential state uses non-blocking assignments only; blocking here
  // would let readers in other always_ff blocks see this cycle's new value.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      div_q <= '0;
      sck   <= 1'b0;
    end else if (clr) begin
      div_q <= '0;
      sck   <= 1'b0;
    end else if (en) begin
      if (term) begin
        div_q <= '0;
        sck   <= ~sck;
      end else begin
        div_q <= div_q + 12'd1;
      end
    end
  end

endmodule

// File: rtl/sd_spi_cmd.sv
// sd_spi_cmd: SPI-mode SD card command initiator (host side).
//   CLK100MHZ, CPU_RESETN     - clock, asynchronous active-low reset
//   init_req                  - pulse: send INIT_CLOCKS SCK cycles, CS high
//   start, cmd_index/arg/crc  - pulse: send one 48-bit command, collect R1
//   busy, done                - operation in progress / one-cycle completion
//   resp, timeout             - R1 byte and no-response flag, valid from done
//   SD_SCK/SD_CMD/SD_MISO/SD_CS_N - SPI mode-0 pins to the card
module sd_spi_cmd
  import sd_pkg::*;
#(
  parameter int CLK_DIV     = 125,
  parameter int INIT_CLOCKS = 80,
  parameter int NCR_MAX     = 64
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic        init_req,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] arg,
  input  logic [6:0]  crc,
  output logic        busy,
  output logic        done,
  output logic [7:0]  resp,
  output logic        timeout,
  output logic        SD_SCK,
  output logic        SD_CMD,
  input  logic        SD_MISO,
  output logic        SD_CS_N
);

  localparam int INIT_W = $clog2(INIT_CLOCKS + 1);

  sd_state_e           state_q, state_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [5:0]          bit_cnt_q, bit_cnt_d;
  logic [6:0]          ncr_q, ncr_d;
  logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
  logic [7:0]          resp_d;
  logic                timeout_d, busy_d, done_d, cs_n_d;
  logic                sck_en, sck_clr, sck_rise, sck_fall;

  // SCK runs only while an operation is in flight; it is forced low on the
  // edge that enters FINISH or IDLE so FINISH always presents SCK=0.
  assign sck_en  = (state_q != IDLE) && (state_q != FINISH);
  assign sck_clr = (state_d == IDLE) || (state_d == FINISH);

  sd_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .CLK100MHZ (CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .en        (sck_en),
    .clr       (sck_clr),
    .sck       (SD_SCK),
    .rise      (sck_rise),
    .fall      (sck_fall)
  );

  // The frame shifter refills with ones, so it is all-ones whenever no frame
  // is being sent; its MSB therefore doubles as the idle-high MOSI level.
  assign SD_CMD = frame_q[FRAME_W-1];

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    ncr_d      = ncr_q;
    init_cnt_d = init_cnt_q;
    resp_d     = resp;
    timeout_d  = timeout;
    busy_d     = busy;
    done_d     = 1'b0;
    cs_n_d     = SD_CS_N;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          frame_d   = build_frame(cmd_index, arg, crc);
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          timeout_d = 1'b0;
          cs_n_d    = 1'b0;
          state_d   = SEND;
        end else if (init_req) begin
          init_cnt_d = '0;
          busy_d     = 1'b1;
          state_d    = INIT;
        end
      end

      INIT: begin
        if (sck_rise) init_cnt_d = init_cnt_q + 1'b1;
        if (sck_fall && (init_cnt_q == INIT_W'(INIT_CLOCKS))) state_d = FINISH;
      end

      SEND: begin
        if (sck_rise) bit_cnt_d = bit_cnt_q + 6'd1;
        if (sck_fall) begin
          frame_d = {frame_q[FRAME_W-2:0], 1'b1};
          if (bit_cnt_q == 6'(FRAME_W)) begin
            ncr_d   = '0;
            state_d = WAIT_R1;
          end
        end
      end

      WAIT_R1: begin
        if (sck_rise) begin
          if (!SD_MISO) begin
            // Shift in from the bottom; seven more shifts land this bit at [7].
            resp_d    = {resp[6:0], SD_MISO};
            bit_cnt_d = '0;
            state_d   = RECV;
          end else if (ncr_q == 7'(NCR_MAX - 1)) begin
            timeout_d = 1'b1;
            resp_d    = R1_IDLE;
            state_d   = FINISH;
          end else begin
            ncr_d = ncr_q + 7'd1;
          end
        end
      end

      RECV: begin
        if (sck_rise && (bit_cnt_q != 6'd7)) begin
          resp_d    = {resp[6:0], SD_MISO};
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
        if (sck_fall && (bit_cnt_q == 6'd7)) state_d = FINISH;
      end

      FINISH: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    if (state_d == FINISH) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      cs_n_d = 1'b1;
    end
  end

  // NOTE: every register here is a small control/data flop with a defined
  // reset value; the async reset drops the card link instantly mid-operation.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q    <= IDLE;
      frame_q    <= '1;
      bit_cnt_q  <= '0;
      ncr_q      <= '0;
      init_cnt_q <= '0;
      resp       <= R1_IDLE;
      timeout    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      SD_CS_N    <= 1'b1;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      ncr_q      <= ncr_d;
      init_cnt_q <= init_cnt_d;
      resp       <= resp_d;
      timeout    <= timeout_d;
      busy       <= busy_d;
      done       <= done_d;
      SD_CS_N    <= cs_n_d;
    end
  end

endmodule
